miriscv_lsu: RTL and testbench
==============================

# miriscv_lsu

Load-store unit that drives the data-memory port of the single-port data RAM from the core side, as the initiator of the req/we/be/addr/wdata/rdata protocol. It turns core load/store requests (address, size code, store data) into word-aligned memory requests with byte enables and replicated write data. It returns sign- or zero-extended load results. It stalls the core for the one-cycle read latency of the RAM.

## Interface
Parameters: none.

Clock and reset (one clock domain; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset

Core side:
- lsu_req_i  in  1  memory access requested this cycle
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  in  32  byte address
- lsu_data_i  in  32  store data, right-aligned
- lsu_data_o  out  32  load result, extended
- lsu_stall_req_o  out  1  core must hold its current instruction
- lsu_misalign_o  out  1  misaligned access detected (see Configuration)

Memory side:
- data_req_o  out  1
- data_we_o  out  1
- data_be_o  out  4
- data_addr_o  out  32  always {lsu_addr_i[31:2], 2'b00}
- data_wdata_o  out  32
- data_rdata_i  in  32  valid the cycle after the request

## Operation
- FSM states: IDLE and WAIT. Reset state is IDLE.
- IDLE, load request (lsu_req_i=1, lsu_we_i=0):
  - Assert data_req_o=1 and data_we_o=0.
  - Assert lsu_stall_req_o=1.
  - Capture lsu_size_i and lsu_addr_i[1:0] into registers.
  - Go to WAIT.
- IDLE, store request:
  - Assert data_req_o=1 and data_we_o=1.
  - lsu_stall_req_o=0.
  - Stay in IDLE (single cycle).
- WAIT:
  - data_req_o=0 and lsu_stall_req_o=0.
  - lsu_data_o is computed from data_rdata_i using the captured size and offset.
  - The result is also written to a hold register.
  - Unconditionally return to IDLE.
  - lsu_req_i is ignored here, because the core still presents the same stalled load.
- Outside WAIT, lsu_data_o shows the hold register (last load result).
- Byte enables and write data:
  - B: be = 4'b0001 << addr[1:0]; wdata = {4{lsu_data_i[7:0]}}.
  - H: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{lsu_data_i[15:0]}}.
  - W: be = 4'b1111; wdata = lsu_data_i.
  - For loads, be is driven the same way; the memory ignores it.
- Load extraction:
  - Byte = rdata >> (8*off), bits [7:0].
  - Half = rdata >> (16*off[1]), bits [15:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Unlisted size codes (011, 110, 111) are treated as W.
- When lsu_req_i=0 in IDLE: data_req_o=0 and data_we_o=0. data_be_o, data_wdata_o and data_addr_o follow the inputs (don't-care to memory).

## Timing
- Load issued in cycle N:
  - data_req_o is high in N.
  - RAM registers data at the N→N+1 edge.
  - lsu_data_o is valid in N+1; the core retires at the end of N+1.
  - Total: exactly 1 stall cycle.
- Store: 0 stall cycles; the write happens at the edge ending the request cycle.
- Back-to-back loads: load, then the next load is issued in the cycle after WAIT. Minimum 2 cycles per load.
- A load in N+2 after a store in N+1 reads the stored value (RAM writes complete first).
- Reset values: lsu_data_o=0, lsu_stall_req_o=0, data_req_o=0, data_we_o=0, data_be_o=0, data_wdata_o=0, lsu_misalign_o=0. The hold register, captured size and captured offset are also 0.
- Async reset asserted in WAIT: immediately forces IDLE and deasserts the stall. The in-flight result is discarded.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - For a misaligned request in IDLE: lsu_misalign_o=1 combinationally that cycle, data_req_o=0, no stall, FSM stays in IDLE, hold register unchanged.
- LSU_MISALIGN_CHECK_EN undefined:
  - lsu_misalign_o is tied to 0.
  - H uses addr[1] only; W ignores addr[1:0].
  - Every access is issued.

## Structure
- Package miriscv_lsu_pkg holds:
  - size localparams LDST_B=3'b000, LDST_H=3'b001, LDST_W=3'b010, LDST_BU=3'b100, LDST_HU=3'b101;
  - the state enum lsu_state_t {LSU_IDLE, LSU_WAIT}.
- One natural sub-module: miriscv_lsu_ext. It is purely combinational: rdata, size and offset in, extended 32-bit result out.

## Test plan
- Reset, then release → all outputs 0 and state IDLE; no data_req_o until lsu_req_i.
- SB addr=0x13, data=0x000000A5 → be=4'b1000, wdata=0xA5A5A5A5, data_addr_o=0x10, stall=0. Then LB 0x13 → stall for 1 cycle, lsu_data_o=0xFFFFFFA5. Then LBU 0x13 → 0x000000A5.
- SH addr=0x22, data=0x8001 → be=4'b1100, wdata=0x80018001. Then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- SW 0x40 = 0xDEADBEEF, then LW 0x40 → 0xDEADBEEF in the cycle after issue. lsu_data_o holds 0xDEADBEEF for 5 idle cycles afterwards.
- Two consecutive LW (0x40, 0x44) with lsu_req_i held high → data_req_o pattern 1,0,1,0, stall pattern 1,0,1,0, correct data each time.
- With LSU_MISALIGN_CHECK_EN, LW 0x41 → lsu_misalign_o=1, data_req_o=0, stall=0, lsu_data_o unchanged. Also: reset asserted during WAIT → stall drops the same cycle and lsu_data_o=0.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// rtl/miriscv_lsu_pkg.sv - size codes, FSM states and lane helpers for the LSU
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_t;

  // Unlisted size codes fall into the word case everywhere.
  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: lsu_be = 4'b0001 << off;
      LDST_H, LDST_HU: lsu_be = 4'b0011 << {off[1], 1'b0};
      default:         lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] data);
    case (size)
      LDST_B, LDST_BU: lsu_wdata = {4{data[7:0]}};
      LDST_H, LDST_HU: lsu_wdata = {2{data[15:0]}};
      default:         lsu_wdata = data;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: lsu_misaligned = 1'b0;
      LDST_H, LDST_HU: lsu_misaligned = off[0];
      default:         lsu_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// rtl/miriscv_lsu_if.sv - data-memory port between LSU (master) and RAM (slave)
interface miriscv_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu_ext.sv
// rtl/miriscv_lsu_ext.sv - extracts and extends the loaded lane from a RAM word
module miriscv_lsu_ext
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_shift = rdata >> {off, 3'b000};
  assign half_shift = rdata >> {off[1], 4'b0000};
  assign byte_v     = byte_shift[7:0];
  assign half_v     = half_shift[15:0];

  // Sign- or zero-extend according to the load flavour.
  always_comb begin
    case (size)
      LDST_B:  result = {{24{byte_v[7]}}, byte_v};
      LDST_BU: result = {24'h000000, byte_v};
      LDST_H:  result = {{16{half_v[15]}}, half_v};
      LDST_HU: result = {16'h0000, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// rtl/miriscv_lsu.sv - load-store unit; define LSU_MISALIGN_CHECK_EN to block misaligned H/W accesses
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         lsu_req_i,
  input  logic         lsu_we_i,
  input  logic [2:0]   lsu_size_i,
  input  logic [31:0]  lsu_addr_i,
  input  logic [31:0]  lsu_data_i,
  output logic [31:0]  lsu_data_o,
  output logic         lsu_stall_req_o,
  output logic         lsu_misalign_o,
  miriscv_lsu_if.master mem
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] hold_q;
  logic [31:0] ext_data;
  logic        misaligned;
  logic        load_start;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  miriscv_lsu_ext u_ext (
    .rdata  (mem.data_rdata_i),
    .size   (size_q),
    .off    (off_q),
    .result (ext_data)
  );

  // Lane steering follows the inputs; held quiet while reset is asserted.
  assign mem.data_addr_o  = {lsu_addr_i[31:2], 2'b00};
  assign mem.data_be_o    = rst_n_i ? lsu_be(lsu_size_i, lsu_addr_i[1:0]) : 4'b0000;
  assign mem.data_wdata_o = rst_n_i ? lsu_wdata(lsu_size_i, lsu_data_i) : 32'h0;

  // In WAIT the RAM word is live; otherwise the last load result is shown.
  assign lsu_data_o = (state_q == LSU_WAIT) ? ext_data : hold_q;

  // Next state and request/stall decode.
  always_comb begin
    state_d         = state_q;
    mem.data_req_o  = 1'b0;
    mem.data_we_o   = 1'b0;
    lsu_stall_req_o = 1'b0;
    lsu_misalign_o  = 1'b0;
    load_start      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (misaligned) begin
            lsu_misalign_o = 1'b1;
          end else begin
            mem.data_req_o = 1'b1;
            mem.data_we_o  = lsu_we_i;
            if (!lsu_we_i) begin
              lsu_stall_req_o = 1'b1;
              load_start      = 1'b1;
              state_d         = LSU_WAIT;
            end
          end
        end
      end
      // The core keeps presenting the same load here, so lsu_req_i is ignored.
      LSU_WAIT: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
    if (!rst_n_i) begin
      mem.data_req_o  = 1'b0;
      mem.data_we_o   = 1'b0;
      lsu_stall_req_o = 1'b0;
      lsu_misalign_o  = 1'b0;
    end
  end

  // State, captured load shape and load-result hold register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LSU_IDLE;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        size_q <= lsu_size_i;
        off_q  <= lsu_addr_i[1:0];
      end
      if (state_q == LSU_WAIT) begin
        hold_q <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb/tb_miriscv_lsu.sv - scoreboard bench for miriscv_lsu against a byte-array memory model
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata_in;
  logic [31:0] lsu_data;
  logic        lsu_stall, lsu_misalign;

  miriscv_lsu_if mem_if ();

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata_in),
    .lsu_data_o      (lsu_data),
    .lsu_stall_req_o (lsu_stall),
    .lsu_misalign_o  (lsu_misalign),
    .mem             (mem_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_mem [0:255];
  logic [31:0] ram [0:63];

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_if.data_req_o) begin
      if (mem_if.data_we_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_if.data_be_o[i]) ram[mem_if.data_addr_o[7:2]][8*i +: 8] <= mem_if.data_wdata_o[8*i +: 8];
      end else begin
        mem_if.data_rdata_i <= ram[mem_if.data_addr_o[7:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Byte offset within the word after dropping address bits below the access size.
  function automatic int eff_off(input logic [2:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int n = nbytes(sz);
    int o = eff_off(sz, a);
    for (int i = 0; i < 4; i++) if (i >= o && i < o + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] w = 32'h0;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int n = nbytes(sz);
    int base = int'(a % 256) - int'(a % 4) + eff_off(sz, a);
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base + k];
    if ((sz == 3'b000 || sz == 3'b001) && v[8*n-1])
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (nbytes(sz) == 2 && a[0]) || (nbytes(sz) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one access starting at posedge+1; returns at posedge+1 after the core may advance.
  task automatic op(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_addr = a; lsu_wdata_in = d;
    if (is_misaligned(sz, a)) begin
      #1;
      chk("mis_flag", {31'h0, lsu_misalign}, 32'h1);
      chk("mis_req", {31'h0, mem_if.data_req_o}, 32'h0);
      chk("mis_stall", {31'h0, lsu_stall}, 32'h0);
      @(posedge clk); #1;
    end else begin
      r.we = we; r.be = exp_be(sz, a); r.addr = {a[31:2], 2'b00}; r.wdata = exp_wdata(sz, d);
      req_q.push_back(r);
      if (we) begin
        for (int k = 0; k < nbytes(sz); k++)
          ref_mem[int'(a % 256) - int'(a % 4) + eff_off(sz, a) + k] = d[8*k +: 8];
        @(posedge clk); #1;
      end else begin
        load_q.push_back(exp_load(sz, a));
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    lsu_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      lsu_we = 1'($urandom); lsu_size = 3'($urandom); lsu_addr = $urandom; lsu_wdata_in = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a request or presents load data.
  initial begin
    logic        pend = 1'b0;
    logic [31:0] last = 32'h0;
    req_t        r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; last = 32'h0;
      end else if (pend) begin
        pend = 1'b0;
        chk("wait_req", {31'h0, mem_if.data_req_o}, 32'h0);
        chk("wait_stall", {31'h0, lsu_stall}, 32'h0);
        if (load_q.size() == 0) chk("load_q_empty", 32'h1, 32'h0);
        else begin
          e = load_q.pop_front();
          chk("load_data", lsu_data, e);
          last = e;
        end
      end else if (mem_if.data_req_o) begin
        chk("req_mis", {31'h0, lsu_misalign}, 32'h0);
        if (req_q.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
        else begin
          r = req_q.pop_front();
          chk("req_we", {31'h0, mem_if.data_we_o}, {31'h0, r.we});
          chk("req_be", {28'h0, mem_if.data_be_o}, {28'h0, r.be});
          chk("req_addr", mem_if.data_addr_o, r.addr);
          chk("req_stall", {31'h0, lsu_stall}, {31'h0, !r.we});
          if (r.we) chk("req_wdata", mem_if.data_wdata_o, r.wdata);
          else pend = 1'b1;
        end
      end else begin
        chk("idle_stall", {31'h0, lsu_stall}, 32'h0);
        chk("idle_hold", lsu_data, last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'b000; lsu_addr = 32'h0; lsu_wdata_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", lsu_data, 32'h0);
    chk("rst_stall", {31'h0, lsu_stall}, 32'h0);
    chk("rst_req", {31'h0, mem_if.data_req_o}, 32'h0);
    chk("rst_we", {31'h0, mem_if.data_we_o}, 32'h0);
    chk("rst_be", {28'h0, mem_if.data_be_o}, 32'h0);
    chk("rst_wdata", mem_if.data_wdata_o, 32'h0);
    chk("rst_mis", {31'h0, lsu_misalign}, 32'h0);
    rst_n = 1'b1;
    idle(4);

    op(1'b1, 3'b000, 32'h13, 32'h000000A5);
    op(1'b0, 3'b000, 32'h13, 32'h0);
    op(1'b0, 3'b100, 32'h13, 32'h0);
    op(1'b1, 3'b001, 32'h22, 32'h00008001);
    op(1'b0, 3'b001, 32'h22, 32'h0);
    op(1'b0, 3'b101, 32'h22, 32'h0);
    op(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    op(1'b0, 3'b010, 32'h40, 32'h0);
    idle(5);
    op(1'b1, 3'b010, 32'h44, 32'h01234567);
    op(1'b0, 3'b010, 32'h40, 32'h0);
    op(1'b0, 3'b010, 32'h44, 32'h0);
    idle(2);
`ifdef LSU_MISALIGN_CHECK_EN
    op(1'b0, 3'b010, 32'h41, 32'h0);
    idle(2);
`endif

    for (int i = 0; i < 300; i++) begin
      logic        we = 1'($urandom);
      logic [2:0]  sz = we ? 3'($urandom_range(0, 3)) : 3'($urandom);
      op(we, sz, 32'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    op(1'b1, 3'b010, 32'h80, 32'h12345678);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b010; lsu_addr = 32'h80;
    req_q.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h80, wdata: 32'h0});
    load_q.push_back(32'h12345678);
    @(posedge clk); #1;
    chk("pre_rst_data", lsu_data, 32'h12345678);
    load_q.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_wait_stall", {31'h0, lsu_stall}, 32'h0);
    chk("rst_wait_data", lsu_data, 32'h0);
    chk("rst_wait_req", {31'h0, mem_if.data_req_o}, 32'h0);
    lsu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    op(1'b0, 3'b010, 32'h80, 32'h0);
    idle(3);

    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("load_q_drained", 32'(load_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
